// File: rtl/cipher_block_scheduler_pkg.sv
// Shared types and constants for the cipher block scheduler: state encoding,
// block/byte widths and a counter-width helper.
package cipher_sched_pkg;

  localparam int AES_BLOCK_W = 128;
  localparam int BYTE_W      = 8;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  // Counter width for a modulo-n index; a single-value range still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cipher_block_scheduler_if.sv
// Block-input and byte-FIFO-output signal bundle for the cipher block scheduler.
interface cipher_sched_if
  import cipher_sched_pkg::*;
#(
  parameter int BLOCK_BYTES = AES_BLOCK_W / BYTE_W
);

  // Handshake: a block transfers on a clk edge where blk_valid && blk_ready;
  // blk_data only has to be stable in that cycle. The byte side has no ready:
  // fifo_w_enable is only raised when fifo_full is low.
  logic                       blk_valid;
  logic [8*BLOCK_BYTES-1:0]   blk_data;
  logic                       blk_ready;
  logic                       abort;
  logic                       fifo_full;
  logic                       fifo_w_enable;
  logic [BYTE_W-1:0]          fifo_w_data;
  logic                       busy;
  logic                       pkt_done;
  logic [15:0]                blk_count;

  modport master (
    output blk_valid, blk_data, abort, fifo_full,
    input  blk_ready, fifo_w_enable, fifo_w_data, busy, pkt_done, blk_count
  );

  modport slave (
    input  blk_valid, blk_data, abort, fifo_full,
    output blk_ready, fifo_w_enable, fifo_w_data, busy, pkt_done, blk_count
  );

endinterface

// File: rtl/cipher_block_scheduler_block_shift_reg.sv
// Loadable block register that shifts one byte per write toward its head byte;
// zeros fill in behind the head.
module block_shift_reg
  import cipher_sched_pkg::*;
#(
  parameter int BLOCK_BYTES = 16,
  parameter bit MSB_FIRST   = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load_i,
  input  logic                          shift_i,
  input  logic [BYTE_W*BLOCK_BYTES-1:0] data_i,
  output logic [BYTE_W-1:0]             head_byte_o
);

  localparam int W = BYTE_W * BLOCK_BYTES;

  logic [W-1:0] data_q, data_d;

  // A load in the same cycle as the final shift starts the next block.
  always_comb begin
    data_d = data_q;
    if (load_i) begin
      data_d = data_i;
    end else if (shift_i) begin
      data_d = MSB_FIRST ? (data_q << BYTE_W) : (data_q >> BYTE_W);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign head_byte_o = MSB_FIRST ? data_q[W-1 -: BYTE_W] : data_q[BYTE_W-1:0];

endmodule

// File: rtl/cipher_block_scheduler.sv
// Serializes accepted cipher blocks into byte FIFO writes, stalling on FIFO full
// and pulsing pkt_done once every BLOCKS_PER_PKT completed blocks.
module cipher_block_scheduler
  import cipher_sched_pkg::*;
#(
  parameter int BLOCK_BYTES    = 16,
  parameter int BLOCKS_PER_PKT = 4,
  parameter bit MSB_FIRST      = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  cipher_sched_if.slave  bus,
  output state_e         state_o
);

  localparam int IDX_W = idx_width(BLOCK_BYTES);
  localparam int PKT_W = idx_width(BLOCKS_PER_PKT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_BYTES - 1);
  localparam logic [PKT_W-1:0] PKT_LAST = PKT_W'(BLOCKS_PER_PKT - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   byte_idx_q, byte_idx_d;
  logic [PKT_W-1:0]   pkt_idx_q, pkt_idx_d;
  logic [15:0]        blk_count_q, blk_count_d;
  logic               pkt_done_q, pkt_done_d;

  logic               load;
  logic               shift;
  logic               blk_ready;
  logic               w_enable;
  logic               busy;
  logic [BYTE_W-1:0]  head_byte;

  block_shift_reg #(
    .BLOCK_BYTES (BLOCK_BYTES),
    .MSB_FIRST   (MSB_FIRST)
  ) u_shift (
    .clk         (clk),
    .rst         (rst),
    .load_i      (load),
    .shift_i     (shift),
    .data_i      (bus.blk_data),
    .head_byte_o (head_byte)
  );

  always_comb begin
    state_d     = state_q;
    byte_idx_d  = byte_idx_q;
    pkt_idx_d   = pkt_idx_q;
    blk_count_d = blk_count_q;
    pkt_done_d  = 1'b0;
    load        = 1'b0;
    shift       = 1'b0;
    blk_ready   = 1'b0;
    w_enable    = 1'b0;
    busy        = (state_q == SEND);

    if (bus.abort) begin
      state_d    = IDLE;
      byte_idx_d = '0;
      pkt_idx_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          blk_ready = 1'b1;
          if (bus.blk_valid) begin
            load       = 1'b1;
            byte_idx_d = '0;
            state_d    = SEND;
          end
        end
        SEND: begin
          if (!bus.fifo_full) begin
            w_enable = 1'b1;
            shift    = 1'b1;
            if (byte_idx_q == LAST_IDX) begin
              // Last byte leaves this cycle, so the next block may be accepted now.
              blk_ready   = 1'b1;
              blk_count_d = blk_count_q + 16'd1;
              byte_idx_d  = '0;
              if (pkt_idx_q == PKT_LAST) begin
                pkt_idx_d  = '0;
                pkt_done_d = 1'b1;
              end else begin
                pkt_idx_d = pkt_idx_q + 1'b1;
              end
              if (bus.blk_valid) begin
                load = 1'b1;
              end else begin
                state_d = IDLE;
              end
            end else begin
              byte_idx_d = byte_idx_q + 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Outputs show the post-reset view for the whole time rst is held.
    if (rst) begin
      blk_ready = 1'b1;
      w_enable  = 1'b0;
      busy      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      byte_idx_q  <= '0;
      pkt_idx_q   <= '0;
      blk_count_q <= '0;
      pkt_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_idx_q  <= byte_idx_d;
      pkt_idx_q   <= pkt_idx_d;
      blk_count_q <= blk_count_d;
      pkt_done_q  <= pkt_done_d;
    end
  end

  assign bus.blk_ready     = blk_ready;
  assign bus.fifo_w_enable = w_enable;
  assign bus.fifo_w_data   = (state_q == SEND && !rst) ? head_byte : '0;
  assign bus.busy          = busy;
  assign bus.pkt_done      = pkt_done_q;
  assign bus.blk_count     = blk_count_q;
  assign state_o           = state_q;

endmodule

// File: tb/tb_cipher_block_scheduler.sv
// Bench for cipher_block_scheduler: an LSB-first and an MSB-first instance share
// stimulus; a byte-queue reference model checks every cycle, plus directed checks.
module tb_cipher_block_scheduler;
  import cipher_sched_pkg::*;

  localparam int BB  = 16;
  localparam int BPP = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cipher_sched_if #(.BLOCK_BYTES(BB)) bus ();
  cipher_sched_if #(.BLOCK_BYTES(BB)) bus2 ();
  state_e state1, state2;

  assign bus2.blk_valid = bus.blk_valid;
  assign bus2.blk_data  = bus.blk_data;
  assign bus2.abort     = bus.abort;
  assign bus2.fifo_full = bus.fifo_full;

  cipher_block_scheduler #(.BLOCK_BYTES(BB), .BLOCKS_PER_PKT(BPP), .MSB_FIRST(1'b0)) dut (
    .clk(clk), .rst(rst), .bus(bus), .state_o(state1)
  );

  cipher_block_scheduler #(.BLOCK_BYTES(BB), .BLOCKS_PER_PKT(BPP), .MSB_FIRST(1'b1)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2), .state_o(state2)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: bytes still owed for the block in flight, in write order.
  logic [7:0] exp_q[$];
  logic [7:0] exp2_q[$];
  logic [7:0] got_q[$];
  logic [7:0] got2_q[$];
  int m_count    = 0;
  int m_pkt      = 0;
  bit m_pkt_done = 1'b0;
  bit hs         = 1'b0;
  int wr_count   = 0;
  int pkt_pulses = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    bit exp_ready;
    bit exp_wen;
    #2;
    if (bus.fifo_w_enable)  got_q.push_back(bus.fifo_w_data);
    if (bus2.fifo_w_enable) got2_q.push_back(bus2.fifo_w_data);
    if (bus.pkt_done) pkt_pulses++;
    hs = 1'b0;
    if (rst) begin
      chk("rst_ready", bus.blk_ready, 1);
      chk("rst_wen", bus.fifo_w_enable, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_wdata", bus.fifo_w_data, 0);
      exp_q.delete();
      exp2_q.delete();
      m_count = 0; m_pkt = 0; m_pkt_done = 1'b0;
    end else begin
      chk("pkt_done", bus.pkt_done, m_pkt_done);
      chk("blk_count", bus.blk_count, 32'(m_count[15:0]));
      chk("busy", bus.busy, exp_q.size() != 0);
      chk("state", state1, (exp_q.size() != 0) ? SEND : IDLE);
      exp_ready = !bus.abort && (exp_q.size() == 0 || (exp_q.size() == 1 && !bus.fifo_full));
      exp_wen   = !bus.abort && !bus.fifo_full && exp_q.size() != 0;
      chk("blk_ready", bus.blk_ready, exp_ready);
      chk("w_enable", bus.fifo_w_enable, exp_wen);
      chk("msb_w_enable", bus2.fifo_w_enable, exp_wen);
      chk("msb_blk_ready", bus2.blk_ready, exp_ready);
      if (exp_q.size() == 0) chk("w_data_idle", bus.fifo_w_data, 0);
      m_pkt_done = 1'b0;
      if (exp_wen) begin
        chk("w_data", bus.fifo_w_data, exp_q.pop_front());
        chk("msb_w_data", bus2.fifo_w_data, exp2_q.pop_front());
        wr_count++;
        if (exp_q.size() == 0) begin
          m_count++;
          m_pkt++;
          if (m_pkt == BPP) begin
            m_pkt = 0;
            m_pkt_done = 1'b1;
          end
        end
      end
      if (bus.abort) begin
        exp_q.delete();
        exp2_q.delete();
        m_pkt = 0;
      end
      if (bus.blk_valid && exp_ready) begin
        hs = 1'b1;
        for (int i = 0; i < BB; i++) begin
          exp_q.push_back(bus.blk_data[8*i +: 8]);
          exp2_q.push_back(bus.blk_data[8*(BB-1-i) +: 8]);
        end
      end
    end
  end

  function automatic logic [127:0] rnd_blk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic send_block(input logic [127:0] d);
    int n = 0;
    @(negedge clk);
    bus.blk_valid = 1'b1;
    bus.blk_data  = d;
    #3;
    while (!hs && n < 100) begin
      @(negedge clk);
      #3;
      n++;
    end
    chk("handshake", hs, 1);
  endtask

  task automatic drop_valid();
    @(negedge clk);
    bus.blk_valid = 1'b0;
    #3;
  endtask

  task automatic wait_writes(input int target);
    int n = 0;
    while (wr_count < target && n < 300) begin
      @(negedge clk);
      #3;
      n++;
    end
    chk("write_budget", wr_count >= target, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #3;
  endtask

  initial begin
    logic [127:0] blk;
    int base;
    int pulses0;
    bus.blk_valid = 1'b0;
    bus.blk_data  = '0;
    bus.abort     = 1'b0;
    bus.fifo_full = 1'b0;

    // Reset state
    idle(3);
    chk("reset_ready", bus.blk_ready, 1);
    chk("reset_wen", bus.fifo_w_enable, 0);
    chk("reset_wdata", bus.fifo_w_data, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_count", bus.blk_count, 0);
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back packet of four blocks
    base = wr_count;
    pulses0 = pkt_pulses;
    for (int b = 0; b < BPP; b++) send_block(rnd_blk());
    drop_valid();
    wait_writes(base + 64);
    idle(3);
    chk("b2b_writes", wr_count - base, 64);
    chk("b2b_pkt_pulses", pkt_pulses - pulses0, 1);
    chk("b2b_count", bus.blk_count, 4);

    // Single known block: LSB-first and MSB-first byte order
    got_q.delete();
    got2_q.delete();
    base = wr_count;
    send_block(128'h0F0E0D0C_0B0A0908_07060504_03020100);
    drop_valid();
    wait_writes(base + 16);
    idle(2);
    chk("single_len", got_q.size(), 16);
    for (int i = 0; i < 16; i++) begin
      chk("single_byte", got_q[i], i);
      chk("msb_byte", got2_q[i], 15 - i);
    end
    chk("single_count", bus.blk_count, 5);
    chk("single_busy", bus.busy, 0);

    // Backpressure: FIFO full for three cycles after the fifth byte
    got_q.delete();
    base = wr_count;
    blk = rnd_blk();
    send_block(blk);
    drop_valid();
    wait_writes(base + 5);
    @(negedge clk); bus.fifo_full = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); bus.fifo_full = 1'b0;
    wait_writes(base + 16);
    idle(2);
    chk("bp_len", got_q.size(), 16);
    for (int i = 0; i < 16; i++) chk("bp_byte", got_q[i], 32'(blk[8*i +: 8]));
    chk("bp_count", bus.blk_count, 6);

    // Abort with nine bytes written, then framing restarts
    got_q.delete();
    base = wr_count;
    send_block(rnd_blk());
    drop_valid();
    wait_writes(base + 9);
    @(negedge clk); bus.abort = 1'b1;
    @(negedge clk); bus.abort = 1'b0;
    #3;
    chk("abort_len", got_q.size(), 9);
    chk("abort_count", bus.blk_count, 6);
    chk("abort_busy", bus.busy, 0);
    got_q.delete();
    base = wr_count;
    pulses0 = pkt_pulses;
    blk = rnd_blk();
    send_block(blk);
    for (int b = 1; b < BPP; b++) send_block(rnd_blk());
    drop_valid();
    wait_writes(base + 64);
    idle(3);
    chk("restart_first_byte", got_q[0], 32'(blk[7:0]));
    chk("restart_pkt_pulses", pkt_pulses - pulses0, 1);
    chk("restart_count", bus.blk_count, 10);

    // Randomized traffic, backpressure and aborts
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      bus.blk_valid = 1'($urandom_range(0, 1));
      bus.blk_data  = rnd_blk();
      bus.fifo_full = ($urandom_range(0, 3) == 0);
      bus.abort     = ($urandom_range(0, 60) == 0);
    end
    @(negedge clk);
    bus.blk_valid = 1'b0;
    bus.fifo_full = 1'b0;
    bus.abort     = 1'b0;
    idle(20);
    chk("drain_busy", bus.busy, 0);

    // Reset in the middle of a block
    base = wr_count;
    send_block(rnd_blk());
    drop_valid();
    wait_writes(base + 7);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    #3;
    chk("midrst_ready", bus.blk_ready, 1);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_wen", bus.fifo_w_enable, 0);
    chk("midrst_count", bus.blk_count, 0);
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cipher_block_scheduler.md
Name: cipher_block_scheduler

Overview:
- Sequences 128-bit AES output blocks into the byte-wide encrypted-data FIFO that feeds the USB transmit path.
- Accepts one block at a time through a valid/ready handshake and emits exactly 16 byte writes, one per cycle.
- Stalls on FIFO full and marks packet boundaries every BLOCKS_PER_PKT blocks.
- Sits between the AES core output and the 8-bit, 16-deep byte FIFO; it replaces free-running, unthrottled write sequencing.

Parameters:
- BLOCK_BYTES, 16: bytes per cipher block; the datapath width is 8*BLOCK_BYTES.
- BLOCKS_PER_PKT, 4: blocks per USB packet; must be at least 1.
- MSB_FIRST, 0: 0 sends byte [7:0] first; 1 sends byte [127:120] first.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- blk_valid  in  1  AES core has a completed block.
- blk_data  in  128  cipher block; sampled only on handshake.
- blk_ready  out  1  scheduler can accept a block this cycle.
- abort  in  1  discard the block in flight and restart packet framing.
- fifo_full  in  1  byte FIFO full.
- fifo_w_enable  out  1  byte write strobe to FIFO.
- fifo_w_data  out  8  byte to FIFO.
- busy  out  1  a block is being serialized.
- pkt_done  out  1  one-cycle pulse: last byte of a packet was written.
- blk_count  out  16  total blocks fully written since reset; wraps at 2^16.

Behaviour:
- Reset and clocking:
  - Only clk is used; rst is synchronous and active-high.
  - While rst=1 at a clk edge: state<=IDLE, byte_idx<=0, pkt_idx<=0, blk_count<=0, pkt_done<=0, shift register<=0.
  - Outputs during and after reset: blk_ready=1, fifo_w_enable=0, fifo_w_data=0, busy=0.
- States: IDLE, SEND.
- IDLE:
  - blk_ready=1, busy=0, fifo_w_enable=0.
  - On blk_valid&blk_ready: load blk_data into the shift register, byte_idx<=0, go to SEND.
- SEND:
  - busy=1.
  - fifo_w_data = current head byte: low byte if MSB_FIRST=0, high byte otherwise.
  - fifo_w_enable = !fifo_full (combinational, same cycle).
  - On each write: shift by 8 toward the head, byte_idx++.
  - fifo_full=1 holds the state, byte_idx and data unchanged; no write occurs.
- Last byte (byte_idx==BLOCK_BYTES-1 and a write occurs):
  - blk_count++.
  - pkt_idx++; when pkt_idx reaches BLOCKS_PER_PKT-1, pkt_idx wraps to 0 and pkt_done is registered high for the next cycle only.
  - blk_ready=1 in this same cycle (pipelined accept).
  - If blk_valid is also high: load the new block, byte_idx<=0, stay in SEND (back-to-back blocks, no bubble).
  - Otherwise go to IDLE.
- blk_ready=0 in every other SEND cycle, including the last-byte cycle when fifo_full=1.
- Latency and throughput:
  - Handshake at cycle T gives the first write at T+1 when the FIFO is not full.
  - Steady-state throughput is 16 cycles per block.
- abort:
  - Highest priority after rst.
  - Forces fifo_w_enable=0 that cycle; next state IDLE; byte_idx<=0, pkt_idx<=0; blk_count unchanged.
  - If abort coincides with the last byte, that byte is not written and the block is not counted.
  - blk_ready=0 during an abort cycle, so no handshake can occur.
- blk_data must be stable only in the handshake cycle; changes outside it are ignored.
- Once accepted, a block is never partially rewritten. Bytes are written exactly once, in order.
- Widths: byte_idx is $clog2(BLOCK_BYTES) bits; pkt_idx is max(1,$clog2(BLOCKS_PER_PKT)) bits.
- BLOCKS_PER_PKT=1: pkt_done pulses after every block.

Decomposition:
- Package cipher_sched_pkg:
  - state enum (IDLE, SEND)
  - AES_BLOCK_W=128
  - BYTE_W=8
- One sub-module, block_shift_reg:
  - loadable 128-bit register that shifts by 8 bits, direction set by MSB_FIRST.
  - head_byte output.
- The FSM, counters and pkt_done register live in the top module.

Test Plan:
- Single block, MSB_FIRST=0, fifo_full=0, blk_data=128'h0F0E_..._0100 → 16 writes on cycles T+1..T+16 with bytes 00,01,…,0F; blk_count=1; blk_ready high at T+16; busy low at T+17.
- Back-to-back: blk_valid held high with 4 distinct blocks → 64 consecutive writes with no gap; pkt_done high for exactly one cycle, the cycle after write 64; blk_count=4.
- Backpressure: fifo_full asserted for 3 cycles after the 5th byte → no fifo_w_enable during those cycles; the 6th byte is written on the first cycle full deasserts; 16 bytes total, none duplicated.
- Abort at byte_idx=9 → only 9 bytes written; blk_count unchanged; pkt_idx=0; the next block starts at byte 00 and packet framing restarts from that block.
- Reset mid-SEND at byte_idx=7 → next cycle blk_ready=1, busy=0, fifo_w_enable=0, blk_count=0.
- MSB_FIRST=1 with the same block as the first scenario → bytes 0F,0E,…,00 in order.
